// File: rtl/param_counter_pkg.sv
// Shared constants and helpers for the cascaded modulus counter.
package param_counter_pkg;

  localparam int SEG_W_DEFAULT = 16;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/cnt_segment.sv
// One up/down counter slice; steps on carry-in, reports its terminal values to the next slice.
module cnt_segment #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_step,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_q,
  output logic             o_term_up,
  output logic             o_term_dn
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_step) begin
      r_q <= i_up ? (r_q + WIDTH'(1)) : (r_q - WIDTH'(1));
    end
  end

  assign o_q       = r_q;
  assign o_term_up = &r_q;
  assign o_term_dn = ~|r_q;

endmodule

// File: rtl/param_mod_counter.sv
// Modulo-MOD up/down counter built from cascaded segments; owns modulus compare,
// load clamping and the wrap / load_err pulse registers.
module param_mod_counter
  import param_counter_pkg::*;
#(
  parameter longint unsigned MOD   = 40000,
  parameter int              SEG_W = SEG_W_DEFAULT,
  localparam int             W     = $clog2(MOD)
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         en,
  input  logic         up,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q,
  output logic         wrap,
  output logic         load_err
);

  localparam int           NSEG    = ceil_div(W, SEG_W);
  localparam logic [W-1:0] MAX_VAL = W'(MOD - 1);

  logic [W-1:0]    w_q;
  logic [NSEG-1:0] w_term_up;
  logic [NSEG-1:0] w_term_dn;
  logic [NSEG:0]   w_carry;
  logic            w_unused_carry;
  logic            w_in_range;
  logic            w_hit;
  logic            w_wrap_step;
  logic            w_force;
  logic [W-1:0]    w_force_val;
  logic            r_wrap;
  logic            r_load_err;

  // A wrap is applied as a forced load of 0 / MAX_VAL, overriding the segment carries.
  always_comb begin
    w_in_range  = 64'(load_val) < MOD;
    w_hit       = (up == DIR_UP) ? (w_q == MAX_VAL) : (w_q == '0);
    w_wrap_step = en & w_hit;
    w_force     = load | w_wrap_step;
    if (load) begin
      w_force_val = w_in_range ? load_val : MAX_VAL;
    end else begin
      w_force_val = (up == DIR_UP) ? '0 : MAX_VAL;
    end
    w_carry    = '0;
    w_carry[0] = en & ~load & ~w_hit;
    for (int k = 1; k <= NSEG; k++) begin
      w_carry[k] = w_carry[k-1] & ((up == DIR_UP) ? w_term_up[k-1] : w_term_dn[k-1]);
    end
  end

  assign w_unused_carry = w_carry[NSEG];

  generate
    for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
      localparam int LO = gi * SEG_W;
      localparam int SW = (gi == NSEG - 1) ? (W - LO) : SEG_W;

      cnt_segment #(
        .WIDTH(SW)
      ) u_seg (
        .clk       (clk),
        .rst_n     (rst_),
        .i_clr     (clr),
        .i_load    (w_force),
        .i_load_val(w_force_val[LO +: SW]),
        .i_step    (w_carry[gi]),
        .i_up      (up),
        .o_q       (w_q[LO +: SW]),
        .o_term_up (w_term_up[gi]),
        .o_term_dn (w_term_dn[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_wrap     <= ~clr & ~load & w_wrap_step;
      r_load_err <= ~clr & load & ~w_in_range;
    end
  end

  assign q        = w_q;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;

endmodule
